// File: rtl/sqrt_periph_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sqrt_periph_pkg                                           |
// | Desc     : Shared register map, bit positions and FSM encoding for   |
// |            the square-root peripheral.                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package sqrt_periph_pkg;

   // Byte offsets of the register map
   localparam logic [4:0] ADDR_OPERAND = 5'h00;
   localparam logic [4:0] ADDR_CTRL    = 5'h04;
   localparam logic [4:0] ADDR_STATUS  = 5'h08;
   localparam logic [4:0] ADDR_RESULT  = 5'h0C;

   // STATUS bit positions
   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;
   localparam int STAT_ERR    = 2;
   localparam int STAT_OVR    = 3;
   localparam int STAT_IRQ_EN = 4;

   // CTRL bit positions
   localparam int CTRL_START  = 0;
   localparam int CTRL_CLR    = 1;
   localparam int CTRL_IRQ_EN = 2;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sqrt_periph_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sqrt_periph_if                                            |
// | Desc     : Simple select/strobe register bus for sqrt_periph.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface sqrt_periph_if;
   logic        cs;
   logic        rd;
   logic        wr;
   logic [4:0]  addr;
   logic [31:0] d_in;
   logic [31:0] d_out;

   modport master (output cs, rd, wr, addr, d_in, input d_out);
   modport slave  (input cs, rd, wr, addr, d_in, output d_out);
endinterface
`default_nettype wire

// File: rtl/sqrt_periph_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sqrt_periph_core                                          |
// | Desc     : Iterative 16-bit integer square root, two operand bits    |
// |            per cycle. init (re)loads A; done stays high until the    |
// |            next init.                                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sqrt_periph_core (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        init,
   input  wire logic [15:0] a,
   output logic [15:0]      result,
   output logic             done
);

   logic [15:0] a_sh_q, a_sh_d;
   logic [17:0] rem_q, rem_d;
   logic [7:0]  root_q, root_d;
   logic [2:0]  iter_q, iter_d;
   logic        run_q, run_d;
   logic        done_q, done_d;

   logic [17:0] w_rem_shift;
   logic [17:0] w_trial;

   assign w_rem_shift = {rem_q[15:0], a_sh_q[15:14]};
   assign w_trial     = {8'b0, root_q, 2'b01};

   // One restoring root-digit step per cycle while running
   always_comb begin
      a_sh_d = a_sh_q;
      rem_d  = rem_q;
      root_d = root_q;
      iter_d = iter_q;
      run_d  = run_q;
      done_d = done_q;
      if (init) begin
         a_sh_d = a;
         rem_d  = '0;
         root_d = '0;
         iter_d = '0;
         run_d  = 1'b1;
         done_d = 1'b0;
      end else if (run_q) begin
         a_sh_d = {a_sh_q[13:0], 2'b00};
         if (w_rem_shift >= w_trial) begin
            rem_d  = w_rem_shift - w_trial;
            root_d = {root_q[6:0], 1'b1};
         end else begin
            rem_d  = w_rem_shift;
            root_d = {root_q[6:0], 1'b0};
         end
         iter_d = iter_q + 3'd1;
         if (iter_q == 3'd7) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // State registers, cleared by the (active-high) core reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_q <= '0;
         rem_q  <= '0;
         root_q <= '0;
         iter_q <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_sh_q <= a_sh_d;
         rem_q  <= rem_d;
         root_q <= root_d;
         iter_q <= iter_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign result = {8'b0, root_q};
   assign done   = done_q;

endmodule
`default_nettype wire

// File: rtl/sqrt_periph.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sqrt_periph                                               |
// | Desc     : Register-mapped wrapper around the sqrt core with launch  |
// |            sequencer, watchdog and sticky error/overrun flags.       |
// |            Define SQRT_PERIPH_IRQ_EN to add the irq output and the   |
// |            CTRL/STATUS irq-enable bit.                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sqrt_periph
   import sqrt_periph_pkg::*;
#(
   parameter int TIMEOUT     = 40,
   parameter int INIT_CYCLES = 2
) (
   input  wire logic     clk,
   input  wire logic     rst,
`ifdef SQRT_PERIPH_IRQ_EN
   output logic          irq,
`endif
   sqrt_periph_if.slave  bus
);

   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam int CNT_W = $clog2(INIT_CYCLES + 1);

   state_t            state_q, state_d;
   logic              init_q, init_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic [15:0]       operand_q, operand_d;
   logic [15:0]       result_q, result_d;
   logic              done_flag_q, done_flag_d;
   logic              err_q, err_d;
   logic              ovr_q, ovr_d;
   logic [31:0]       d_out_q, d_out_d;

   logic              w_core_rst;
   logic [15:0]       w_core_result;
   logic              w_core_done;
   logic              w_wr_en, w_rd_en, w_start;
   logic [WD_W-1:0]   w_wdog_inc;
   logic              w_irq_en;
   logic [31:0]       w_status;
   logic              w_unused_d_in;

   assign w_core_rst    = ~rst;
   assign w_wr_en       = bus.cs & bus.wr;
   assign w_rd_en       = bus.cs & bus.rd;
   assign w_start       = w_wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[CTRL_START];
   assign w_wdog_inc    = wdog_q + WD_W'(1);
   assign w_unused_d_in = ^bus.d_in[31:16];

   sqrt_periph_core u_core (
      .clk    (clk),
      .rst    (w_core_rst),
      .init   (init_q),
      .a      (operand_q),
      .result (w_core_result),
      .done   (w_core_done)
   );

`ifdef SQRT_PERIPH_IRQ_EN
   logic irq_en_q, irq_q;

   // irq enable is written through CTRL; irq follows the registered flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (w_wr_en && (bus.addr == ADDR_CTRL))
            irq_en_q <= bus.d_in[CTRL_IRQ_EN];
         irq_q <= irq_en_q & (done_flag_q | err_q);
      end
   end

   assign w_irq_en = irq_en_q;
   assign irq      = irq_q;
`else
   assign w_irq_en = 1'b0;
`endif

   always_comb begin
      w_status              = '0;
      w_status[STAT_BUSY]   = (state_q != ST_IDLE);
      w_status[STAT_DONE]   = done_flag_q;
      w_status[STAT_ERR]    = err_q;
      w_status[STAT_OVR]    = ovr_q;
      w_status[STAT_IRQ_EN] = w_irq_en;
   end

   // Register writes, launch sequencing, watchdog and read-data mux.
   // Operand is frozen outside IDLE so the core input stays stable.
   always_comb begin
      state_d     = state_q;
      init_d      = init_q;
      cnt_d       = cnt_q;
      wdog_d      = wdog_q;
      operand_d   = operand_q;
      result_d    = result_q;
      done_flag_d = done_flag_q;
      err_d       = err_q;
      ovr_d       = ovr_q;
      d_out_d     = d_out_q;

      if (w_wr_en && (bus.addr == ADDR_OPERAND) && (state_q == ST_IDLE))
         operand_d = bus.d_in[15:0];
      if (w_wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[CTRL_CLR]) begin
         err_d = 1'b0;
         ovr_d = 1'b0;
      end
      // Reading RESULT acknowledges completion; a capture below overrides it
      if (w_rd_en && (bus.addr == ADDR_RESULT))
         done_flag_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_start) begin
               state_d     = ST_LAUNCH;
               init_d      = 1'b1;
               cnt_d       = '0;
               wdog_d      = '0;
               done_flag_d = 1'b0;
            end
         end
         ST_LAUNCH: begin
            wdog_d = w_wdog_inc;
            if (w_wdog_inc == WD_W'(TIMEOUT)) begin
               state_d = ST_IDLE;
               init_d  = 1'b0;
               err_d   = 1'b1;
            end else if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
               state_d = ST_WAIT;
               init_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            wdog_d = w_wdog_inc;
            if (w_core_done) begin
               state_d     = ST_HOLD;
               result_d    = w_core_result;
               done_flag_d = 1'b1;
            end else if (w_wdog_inc == WD_W'(TIMEOUT)) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (w_start && (state_q != ST_IDLE))
         ovr_d = 1'b1;

      if (w_rd_en) begin
         case (bus.addr)
            ADDR_OPERAND: d_out_d = {16'b0, operand_q};
            ADDR_STATUS:  d_out_d = w_status;
            ADDR_RESULT:  d_out_d = {16'b0, result_q};
            default:      d_out_d = '0;
         endcase
      end
   end

   // Peripheral state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         init_q      <= 1'b0;
         cnt_q       <= '0;
         wdog_q      <= '0;
         operand_q   <= '0;
         result_q    <= '0;
         done_flag_q <= 1'b0;
         err_q       <= 1'b0;
         ovr_q       <= 1'b0;
         d_out_q     <= '0;
      end else begin
         state_q     <= state_d;
         init_q      <= init_d;
         cnt_q       <= cnt_d;
         wdog_q      <= wdog_d;
         operand_q   <= operand_d;
         result_q    <= result_d;
         done_flag_q <= done_flag_d;
         err_q       <= err_d;
         ovr_q       <= ovr_d;
         d_out_q     <= d_out_d;
      end
   end

   assign bus.d_out = d_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_periph.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sqrt_periph                                            |
// | Desc     : Directed + random bench for sqrt_periph with a plain      |
// |            arithmetic square-root reference. A second instance with  |
// |            a short TIMEOUT exercises the watchdog abort.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_sqrt_periph;
   import sqrt_periph_pkg::*;

   localparam int SHORT_TIMEOUT = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        tb_cs, tb_rd, tb_wr, sel2;
   logic [4:0]  tb_addr;
   logic [31:0] tb_din;
   logic [31:0] rdata;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   sqrt_periph_if bus_if ();
   sqrt_periph_if bus2_if ();

   assign bus_if.cs    = tb_cs & ~sel2;
   assign bus_if.rd    = tb_rd;
   assign bus_if.wr    = tb_wr;
   assign bus_if.addr  = tb_addr;
   assign bus_if.d_in  = tb_din;
   assign bus2_if.cs   = tb_cs & sel2;
   assign bus2_if.rd   = tb_rd;
   assign bus2_if.wr   = tb_wr;
   assign bus2_if.addr = tb_addr;
   assign bus2_if.d_in = tb_din;
   assign rdata        = sel2 ? bus2_if.d_out : bus_if.d_out;

`ifdef SQRT_PERIPH_IRQ_EN
   logic irq, irq2;
`endif

   sqrt_periph dut (
      .clk (clk),
      .rst (rst),
`ifdef SQRT_PERIPH_IRQ_EN
      .irq (irq),
`endif
      .bus (bus_if.slave)
   );

   sqrt_periph #(.TIMEOUT(SHORT_TIMEOUT), .INIT_CYCLES(2)) dut2 (
      .clk (clk),
      .rst (rst),
`ifdef SQRT_PERIPH_IRQ_EN
      .irq (irq2),
`endif
      .bus (bus2_if.slave)
   );

   // Reference: largest r with r*r <= a
   function automatic logic [31:0] ref_sqrt(input int unsigned a);
      int unsigned r = 0;
      while ((r + 1) * (r + 1) <= a) r++;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      tb_cs = 1'b1; tb_wr = 1'b1; tb_rd = 1'b0; tb_addr = a; tb_din = d;
      @(posedge clk); #1;
      tb_cs = 1'b0; tb_wr = 1'b0;
   endtask

   task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      tb_cs = 1'b1; tb_rd = 1'b1; tb_wr = 1'b0; tb_addr = a;
      @(posedge clk); #1;
      d = rdata;
      tb_cs = 1'b0; tb_rd = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] st;
      st = 32'h1;
      for (int i = 0; i < 100 && st[STAT_BUSY]; i++) bus_rd(ADDR_STATUS, st);
      check(tag, {31'b0, st[STAT_BUSY]}, 32'h0);
   endtask

   task automatic run_op(input logic [15:0] op);
      logic [31:0] r;
      bus_wr(ADDR_OPERAND, {16'b0, op});
      bus_wr(ADDR_CTRL, 32'h1);
      wait_idle("op_idle");
      bus_rd(ADDR_RESULT, r);
      check($sformatf("sqrt(%0d)", op), r, ref_sqrt(op));
   endtask

   initial begin
      logic [31:0] r;
      int hi, k;
      rst = 1'b0; sel2 = 1'b0;
      tb_cs = 1'b0; tb_rd = 1'b0; tb_wr = 1'b0; tb_addr = '0; tb_din = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_dout", bus_if.d_out, 32'h0);
      @(negedge clk) rst = 1'b1;

      bus_rd(ADDR_STATUS, r);  check("reset_status", r, 32'h0);
      bus_rd(ADDR_OPERAND, r); check("reset_operand", r, 32'h0);
      bus_rd(ADDR_RESULT, r);  check("reset_result", r, 32'h0);
      bus_rd(ADDR_CTRL, r);    check("ctrl_reads_0", r, 32'h0);

      // 400 -> 20, with init pulse width measured
      bus_wr(ADDR_OPERAND, 32'h0190);
      bus_rd(ADDR_OPERAND, r); check("operand_rb", r, 32'h0190);
      bus_wr(ADDR_CTRL, 32'h1);
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         if (dut.init_q) hi++;
         @(posedge clk); #1;
      end
      check("init_cycles", hi, 32'd2);
      wait_idle("idle_400");
      bus_rd(ADDR_STATUS, r); check("status_done", r, 32'h2);
      bus_rd(ADDR_RESULT, r); check("result_400", r, 32'h14);
      bus_rd(ADDR_STATUS, r); check("done_cleared", r, 32'h0);

      // Busy right after start; operand writes ignored while busy
      bus_wr(ADDR_OPERAND, 32'hFFFF);
      bus_wr(ADDR_CTRL, 32'h1);
      bus_rd(ADDR_STATUS, r); check("busy_next", r, 32'h1);
      bus_wr(ADDR_OPERAND, 32'h1234);
      wait_idle("idle_ffff");
      bus_rd(ADDR_OPERAND, r); check("operand_locked", r, 32'hFFFF);
      bus_rd(ADDR_RESULT, r);  check("result_ffff", r, 32'hFF);

      run_op(16'h0000);
      for (int i = 0; i < 6; i++) run_op(16'($urandom_range(0, 65535)));

      // Overrun: start during computation
      bus_wr(ADDR_OPERAND, 32'd1000);
      bus_wr(ADDR_CTRL, 32'h1);
      repeat (4) @(posedge clk);
      bus_wr(ADDR_CTRL, 32'h1);
      bus_rd(ADDR_STATUS, r); check("ovr_set", {31'b0, r[STAT_OVR]}, 32'h1);
      wait_idle("idle_ovr");
      bus_rd(ADDR_STATUS, r); check("status_ovr_done", r, 32'hA);
      bus_rd(ADDR_RESULT, r); check("result_1000", r, ref_sqrt(1000));
      bus_wr(ADDR_CTRL, 32'h2);
      bus_rd(ADDR_STATUS, r); check("ovr_cleared", r, 32'h0);

      // Simultaneous read and write of OPERAND
      @(negedge clk);
      tb_cs = 1'b1; tb_rd = 1'b1; tb_wr = 1'b1; tb_addr = ADDR_OPERAND; tb_din = 32'h77;
      @(posedge clk); #1;
      r = rdata;
      tb_cs = 1'b0; tb_rd = 1'b0; tb_wr = 1'b0;
      check("rdwr_old", r, 32'd1000);
      bus_rd(ADDR_OPERAND, r); check("rdwr_new", r, 32'h77);

      // Watchdog abort on the short-timeout instance
      sel2 = 1'b1;
      bus_wr(ADDR_OPERAND, 32'h0190);
      bus_wr(ADDR_CTRL, 32'h1);
      k = 0;
      while (!dut2.err_q && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("timeout_cycles", k, SHORT_TIMEOUT);
      bus_rd(ADDR_STATUS, r); check("timeout_status", r, 32'h4);
      bus_rd(ADDR_RESULT, r); check("timeout_result", r, 32'h0);
      bus_wr(ADDR_CTRL, 32'h2);
      bus_rd(ADDR_STATUS, r); check("err_cleared", r, 32'h0);
      sel2 = 1'b0;

      // Asynchronous reset in the middle of a computation
      bus_rd(ADDR_OPERAND, r);
      bus_wr(ADDR_CTRL, 32'h1);
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_dout", bus_if.d_out, 32'h0);
      check("async_init", {31'b0, dut.init_q}, 32'h0);
      @(negedge clk) rst = 1'b1;
      repeat (20) @(posedge clk);
      bus_rd(ADDR_STATUS, r);  check("post_rst_status", r, 32'h0);
      bus_rd(ADDR_RESULT, r);  check("post_rst_result", r, 32'h0);
      bus_rd(ADDR_OPERAND, r); check("post_rst_operand", r, 32'h0);

`ifdef SQRT_PERIPH_IRQ_EN
      bus_wr(ADDR_OPERAND, 32'h0190);
      check("irq_low", {31'b0, irq}, 32'h0);
      bus_wr(ADDR_CTRL, 32'h5);
      wait_idle("idle_irq");
      repeat (2) @(posedge clk);
      #1;
      check("irq_high", {31'b0, irq}, 32'h1);
      bus_rd(ADDR_STATUS, r); check("status_irq_en", r, 32'h12);
      bus_rd(ADDR_RESULT, r); check("irq_result", r, 32'h14);
      @(posedge clk); #1;
      check("irq_fell", {31'b0, irq}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global guard so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
